gen_pipe_skid_dff: RTL and testbench

- Parametrised successor of the plain pipeline flop: one pipeline stage with a valid/ready handshake on both sides.
- A 2-entry skid buffer means in_ready never depends combinationally on out_ready, which breaks the backpressure timing path between tiny_riscv pipeline stages.
- Keeps the existing pipe-flop features: hold (stall) and a def_val bubble output. Adds synchronous flush and an occupancy readout.
- Sits between IF/ID/EX stages wherever a stall must propagate upstream without a long combinational ready chain.

---
 rtl/gen_pipe_skid_dff.sv | 91 +++++++++
 tb/tb_gen_pipe_skid_dff.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gen_pipe_skid_dff.sv
`default_nettype none
// ============================================================================
// Module   : gen_pipe_skid_dff
// Brief    : One pipeline stage with valid/ready handshakes and a 2-entry skid
//            buffer, so in_ready is registered-state-only (no out_ready path).
//            Supports stall (hold_en), synchronous flush and occupancy readout.
// Revision : 1.0  initial release
// ============================================================================
module gen_pipe_skid_dff #(
    parameter int            DW      = 32,
    parameter logic [DW-1:0] RST_VAL = {DW{1'b0}}
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          hold_en,
    input  logic [DW-1:0] def_val,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] din,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] qout,
    output logic [1:0]    occupancy
);

    // State code equals the number of held entries.
    localparam logic [1:0] c_ST_EMPTY = 2'd0;
    localparam logic [1:0] c_ST_ONE   = 2'd1;
    localparam logic [1:0] c_ST_TWO   = 2'd2;
    localparam logic [1:0] c_ST_ILL   = 2'd3;

    logic [1:0]    r_state;
    logic [DW-1:0] r_main;
    logic [DW-1:0] r_skid;
    logic          w_in_ready;
    logic          w_out_valid;
    logic          w_accept;
    logic          w_pop;

    assign w_in_ready  = rst & (r_state != c_ST_TWO) & ~hold_en & ~flush;
    assign w_out_valid = (r_state != c_ST_EMPTY) & ~hold_en & ~flush;
    assign w_accept    = in_valid & w_in_ready;
    assign w_pop       = w_out_valid & out_ready;

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign qout      = w_out_valid ? r_main : def_val;
    assign occupancy = r_state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_ST_EMPTY;
            r_main  <= RST_VAL;
            r_skid  <= RST_VAL;
        end else if (r_state == c_ST_ILL) begin
            r_state <= c_ST_EMPTY;
        end else if (flush) begin
            r_state <= c_ST_EMPTY;
        end else if (!hold_en) begin
            case (r_state)
                c_ST_EMPTY: begin
                    if (w_accept) begin
                        r_main  <= din;
                        r_state <= c_ST_ONE;
                    end
                end
                c_ST_ONE: begin
                    if (w_accept && w_pop) begin
                        r_main <= din;
                    end else if (w_accept) begin
                        r_skid  <= din;
                        r_state <= c_ST_TWO;
                    end else if (w_pop) begin
                        r_state <= c_ST_EMPTY;
                    end
                end
                c_ST_TWO: begin
                    // Skid entry is older than anything upstream; promote it.
                    if (w_pop) begin
                        r_main  <= r_skid;
                        r_state <= c_ST_ONE;
                    end
                end
                default: r_state <= c_ST_EMPTY;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gen_pipe_skid_dff.sv
`default_nettype none
// ============================================================================
// Module   : tb_gen_pipe_skid_dff
// Brief    : Self-checking bench for gen_pipe_skid_dff using a queue model.
// Revision : 1.0  initial release
// ============================================================================
module tb_gen_pipe_skid_dff;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          hold_en;
    logic [DW-1:0] def_val;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] din;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] qout;
    logic [1:0]    occupancy;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [DW-1:0] q[$];

    gen_pipe_skid_dff #(.DW(DW), .RST_VAL('0)) dut (
        .clk(clk), .rst(rst), .flush(flush), .hold_en(hold_en),
        .def_val(def_val), .in_valid(in_valid), .in_ready(in_ready),
        .din(din), .out_valid(out_valid), .out_ready(out_ready),
        .qout(qout), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    function automatic logic m_valid();
        return (q.size() != 0) && !hold_en && !flush;
    endfunction

    function automatic logic m_ready();
        return rst && (q.size() < 2) && !hold_en && !flush;
    endfunction

    function automatic logic [DW+3:0] m_vec();
        logic [DW-1:0] v;
        v = m_valid() ? q[0] : def_val;
        return {m_valid(), m_ready(), 2'(q.size()), v};
    endfunction

    // Advance one clock; the model moves from the inputs seen before the edge.
    task automatic tick();
        logic acc, pp;
        logic [DW-1:0] d;
        acc = in_valid && m_ready();
        pp  = m_valid() && out_ready;
        d   = din;
        @(posedge clk);
        if (rst) begin
            if (flush) q.delete();
            else if (!hold_en) begin
                if (pp) void'(q.pop_front());
                if (acc) q.push_back(d);
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        flush = 0; hold_en = 0; in_valid = 0; out_ready = 0; din = '0;
    endtask

    task automatic test_reset();
        logic [DW+3:0] act;
        rst = 0; def_val = 32'hDEAD_BEEF; idle_inputs();
        q.delete();
        repeat (3) tick();
        act = {out_valid, in_ready, occupancy, qout};
        n_cmp++;
        if (act !== {1'b0, 1'b0, 2'd0, 32'hDEAD_BEEF}) begin
            n_fail++; $display("FAIL reset_state: got %h expected %h", act, {1'b0, 1'b0, 2'd0, 32'hDEAD_BEEF});
        end
        #2 rst = 1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL release_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_stream();
        logic [DW+3:0] act;
        in_valid = 1; out_ready = 1;
        for (int i = 1; i <= 4; i++) begin
            din = DW'(i);
            #1;
            act = {out_valid, in_ready, occupancy, qout};
            n_cmp++;
            if (act !== m_vec()) begin
                n_fail++; $display("FAIL stream_cycle%0d: got %h expected %h", i, act, m_vec());
            end
            tick();
            n_cmp++;
            if (qout !== DW'(i) || occupancy !== 2'd1 || in_ready !== 1'b1) begin
                n_fail++; $display("FAIL stream_out%0d: got q=%h occ=%0d rdy=%b expected q=%h occ=1 rdy=1",
                                   i, qout, occupancy, in_ready, i);
            end
        end
        in_valid = 0;
        tick();
    endtask

    task automatic test_skid();
        logic [DW-1:0] words[3];
        logic [DW-1:0] got[$];
        int idx;
        words[0] = 32'hA0A0_0001; words[1] = 32'hB0B0_0002; words[2] = 32'hC0C0_0003;
        idx = 0; out_ready = 0; in_valid = 1;
        repeat (3) begin
            din = words[idx];
            #1;
            if (in_valid && m_ready()) idx++;
            tick();
        end
        n_cmp++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0 || idx != 2) begin
            n_fail++; $display("FAIL skid_full: got occ=%0d rdy=%b expected occ=2 rdy=0", occupancy, in_ready);
        end
        out_ready = 1;
        for (int c = 0; c < 10 && got.size() < 3; c++) begin
            in_valid = (idx < 3);
            din = words[idx < 3 ? idx : 2];
            #1;
            if (out_valid) got.push_back(qout);
            if (in_valid && m_ready()) idx++;
            tick();
        end
        in_valid = 0;
        n_cmp++;
        if (got.size() != 3) begin
            n_fail++; $display("FAIL skid_count: got %0d words expected 3", got.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (got[k] !== words[k]) begin
                    n_fail++; $display("FAIL skid_order%0d: got %h expected %h", k, got[k], words[k]);
                end
            end
        end
        tick();
    endtask

    task automatic fill_two(input logic [DW-1:0] a, input logic [DW-1:0] b);
        out_ready = 0; in_valid = 1;
        din = a; tick();
        din = b; tick();
        in_valid = 0;
    endtask

    task automatic test_hold();
        logic [DW-1:0] got[$];
        fill_two(32'h1111_2222, 32'h3333_4444);
        def_val = 32'h0BAD_F00D;
        hold_en = 1; out_ready = 1;
        repeat (3) begin
            #1;
            n_cmp++;
            if ({out_valid, in_ready, occupancy, qout} !== {1'b0, 1'b0, 2'd2, 32'h0BAD_F00D}) begin
                n_fail++; $display("FAIL hold_frozen: got %h expected %h",
                                   {out_valid, in_ready, occupancy, qout}, {1'b0, 1'b0, 2'd2, 32'h0BAD_F00D});
            end
            tick();
        end
        hold_en = 0;
        for (int c = 0; c < 4 && got.size() < 2; c++) begin
            #1;
            if (out_valid) got.push_back(qout);
            tick();
        end
        n_cmp++;
        if (got.size() != 2 || got[0] !== 32'h1111_2222 || got[1] !== 32'h3333_4444) begin
            n_fail++; $display("FAIL hold_release: got %0d words first %h expected 11112222,33334444",
                               got.size(), got.size() > 0 ? got[0] : '0);
        end
    endtask

    task automatic test_flush();
        fill_two(32'h5555_0001, 32'h5555_0002);
        in_valid = 1; din = 32'h7777_7777; flush = 1; hold_en = 1; out_ready = 1;
        tick();
        flush = 0; hold_en = 0; in_valid = 0;
        #1;
        n_cmp++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_empty: got occ=%0d vld=%b expected occ=0 vld=0", occupancy, out_valid);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            n_fail++; $display("FAIL flush_no_capture: got vld=%b q=%h expected vld=0", out_valid, qout);
        end
    endtask

    task automatic test_async_reset();
        fill_two(32'h9999_0001, 32'h9999_0002);
        #3 rst = 0; q.delete();
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            n_fail++; $display("FAIL async_reset: got vld=%b occ=%0d expected vld=0 occ=0", out_valid, occupancy);
        end
        tick();
        #2 rst = 1;
        in_valid = 1; din = 32'h0000_0055; out_ready = 0;
        tick();
        in_valid = 0;
        #1;
        n_cmp++;
        if ({out_valid, occupancy, qout} !== {1'b1, 2'd1, 32'h0000_0055}) begin
            n_fail++; $display("FAIL post_reset_word: got %h expected %h",
                               {out_valid, occupancy, qout}, {1'b1, 2'd1, 32'h0000_0055});
        end
        out_ready = 1;
        tick();
        out_ready = 0;
    endtask

    task automatic test_random();
        logic [DW+3:0] act;
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            din       = $urandom;
            def_val   = $urandom;
            hold_en   = ($urandom_range(0, 9) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            #1;
            act = {out_valid, in_ready, occupancy, qout};
            n_cmp++;
            if (act !== m_vec()) begin
                n_fail++; $display("FAIL random_cycle%0d: got %h expected %h", i, act, m_vec());
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_skid();
        test_hold();
        test_flush();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
